// File: rtl/vexec_pkg.sv
// vexec_pkg: shared types and helpers for the registered SIMD execute stage.
// Latency: n/a (types and combinational helper functions only).
// Backpressure: n/a.
package vexec_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_SRL  = 3'd5,
    OP_MULQ = 3'd6,
    OP_RSVD = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MULT  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Intermediate width for range checks; wide enough for a full 2*LANE_W
  // signed product with LANE_W up to 64.
  localparam int SAT_W = 128;
  typedef logic signed [SAT_W-1:0] wide_t;

  // Largest value representable as a w-bit signed number.
  function automatic wide_t smax(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  // True when v fits in a w-bit signed number.
  function automatic logic fits_signed(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    hi = smax(w);
    lo = ~hi;
    return (v <= hi) && (v >= lo);
  endfunction

  // Clamp v to the w-bit signed range; in-range values pass unchanged.
  function automatic wide_t sat_clamp(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    hi = smax(w);
    lo = ~hi;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/vexec_lane.sv
// vexec_lane: one SIMD lane of ALU, fixed-point multiply, saturation and overflow.
// Latency: combinational.
// Backpressure: none; the parent decides when the lane output is registered.
// Ports: op_i/sat_i select the operation, a_i/b_i operands, wr_i lane write
// enable (0 passes a_i through), res_o result, zero_o/ovf_o lane flags.
module vexec_lane
  import vexec_pkg::*;
#(
  parameter int LANE_W = 32,
  parameter int FRAC   = 8
) (
  input  op_t               op_i,
  input  logic              sat_i,
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  input  logic              wr_i,
  output logic [LANE_W-1:0] res_o,
  output logic              zero_o,
  output logic              ovf_o
);

  localparam int SHW = $clog2(LANE_W);

  logic signed [LANE_W:0]     add_w;
  logic signed [LANE_W:0]     sub_w;
  logic signed [2*LANE_W-1:0] prod_w;
  logic signed [2*LANE_W-1:0] prodq_w;

  always_comb begin
    add_w   = {a_i[LANE_W-1], a_i} + {b_i[LANE_W-1], b_i};
    sub_w   = {a_i[LANE_W-1], a_i} - {b_i[LANE_W-1], b_i};
    // Operands sign-extended to full product width so the product is exact.
    prod_w  = $signed({{LANE_W{a_i[LANE_W-1]}}, a_i}) *
              $signed({{LANE_W{b_i[LANE_W-1]}}, b_i});
    // Arithmetic shift floors toward minus infinity.
    prodq_w = prod_w >>> FRAC;

    res_o = '0;
    ovf_o = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        ovf_o = !fits_signed(wide_t'(add_w), LANE_W);
        res_o = sat_i ? LANE_W'(sat_clamp(wide_t'(add_w), LANE_W)) : add_w[LANE_W-1:0];
      end
      OP_SUB: begin
        ovf_o = !fits_signed(wide_t'(sub_w), LANE_W);
        res_o = sat_i ? LANE_W'(sat_clamp(wide_t'(sub_w), LANE_W)) : sub_w[LANE_W-1:0];
      end
      OP_MUL: begin
        ovf_o = !fits_signed(wide_t'(prod_w), LANE_W);
        res_o = prod_w[LANE_W-1:0];
      end
      OP_MULQ: begin
        ovf_o = !fits_signed(wide_t'(prodq_w), LANE_W);
        res_o = sat_i ? LANE_W'(sat_clamp(wide_t'(prodq_w), LANE_W)) : prodq_w[LANE_W-1:0];
      end
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_SRL:  res_o = a_i >> b_i[SHW-1:0];
      default: begin
        res_o = '0;
        ovf_o = 1'b0;
      end
    endcase

    // Unwritten lanes keep operand A and never flag overflow.
    if (!wr_i) begin
      res_o = a_i;
      ovf_o = 1'b0;
    end
    zero_o = (res_o == '0);
  end

endmodule

// File: rtl/vexec_pipe.sv
// vexec_pipe: registered SIMD execute stage with masking, saturation and multi-cycle multiply.
// Latency: 1 cycle for ALU ops, MUL_LAT-1 cycles after accept for MUL/MULQ.
// Backpressure: one-entry output register; in_ready drops while a multiply runs or a result is unclaimed.
// Ports: in_valid/in_ready + op/sat/operand selects/operands/lane_mask on the input side;
// out_valid/out_ready + result/lane_zero/lane_ovf on the output side; flush aborts, busy flags a multiply.
module vexec_pipe
  import vexec_pkg::*;
#(
  parameter int LANES   = 8,
  parameter int LANE_W  = 32,
  parameter int MUL_LAT = 3,
  parameter int FRAC    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              op,
  input  logic                    sat,
  input  logic                    a_fwd,
  input  logic                    b_fwd,
  input  logic                    a_vsel,
  input  logic                    b_vsel,
  input  logic [LANE_W-1:0]       a_s,
  input  logic [LANE_W-1:0]       b_s,
  input  logic [LANE_W-1:0]       fwd_s,
  input  logic [LANES*LANE_W-1:0] a_v,
  input  logic [LANES*LANE_W-1:0] b_v,
  input  logic [LANES*LANE_W-1:0] fwd_v,
  input  logic [LANES-1:0]        lane_mask,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] result,
  output logic [LANES-1:0]        lane_zero,
  output logic [LANES-1:0]        lane_ovf,
  output logic                    busy
);

  localparam int VW    = LANES * LANE_W;
  localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]      res_q, res_d;
  logic [LANES-1:0]   zero_q, zero_d;
  logic [LANES-1:0]   ovf_q, ovf_d;
  // Operands captured at accept, consumed while the multiply is in flight.
  logic [VW-1:0]      a_q, a_d;
  logic [VW-1:0]      b_q, b_d;
  op_t                op_q, op_d;
  logic               sat_q, sat_d;
  logic [LANES-1:0]   mask_q, mask_d;

  logic [LANE_W-1:0]  a_src_s, b_src_s;
  logic [VW-1:0]      a_src_v, b_src_v;
  logic [VW-1:0]      a_live, b_live;
  op_t                op_live;
  logic               is_mul_live;
  logic               in_mult;
  logic               accept, take;

  op_t                alu_op;
  logic               alu_sat;
  logic [VW-1:0]      alu_a, alu_b;
  logic [LANES-1:0]   alu_wr;
  logic [VW-1:0]      alu_res;
  logic [LANES-1:0]   alu_zero, alu_ovf;

  // Operand selection: forwarded vs register source, then vector vs broadcast.
  assign a_src_s = a_fwd ? fwd_s : a_s;
  assign b_src_s = b_fwd ? fwd_s : b_s;
  assign a_src_v = a_fwd ? fwd_v : a_v;
  assign b_src_v = b_fwd ? fwd_v : b_v;
  assign a_live  = a_vsel ? a_src_v : {LANES{a_src_s}};
  assign b_live  = b_vsel ? b_src_v : {LANES{b_src_s}};

  assign op_live     = op_t'(op);
  assign is_mul_live = (op_live == OP_MUL) || (op_live == OP_MULQ);

  assign in_mult   = (state_q == ST_MULT);
  assign out_valid = (state_q == ST_FULL);
  assign busy      = in_mult;
  // flush wins over a simultaneous offer; in_ready is low throughout reset.
  assign in_ready  = rst_n && !flush &&
                     ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && out_ready));
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  // One set of lanes serves both paths: live operands for single-cycle ops,
  // captured operands while a multiply counts down (a multi-cycle path).
  assign alu_op  = in_mult ? op_q   : op_live;
  assign alu_sat = in_mult ? sat_q  : sat;
  assign alu_a   = in_mult ? a_q    : a_live;
  assign alu_b   = in_mult ? b_q    : b_live;
  assign alu_wr  = in_mult ? mask_q : lane_mask;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vexec_lane #(
      .LANE_W (LANE_W),
      .FRAC   (FRAC)
    ) u_lane (
      .op_i   (alu_op),
      .sat_i  (alu_sat),
      .a_i    (alu_a[i*LANE_W +: LANE_W]),
      .b_i    (alu_b[i*LANE_W +: LANE_W]),
      .wr_i   (alu_wr[i]),
      .res_o  (alu_res[i*LANE_W +: LANE_W]),
      .zero_o (alu_zero[i]),
      .ovf_o  (alu_ovf[i])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sat_d   = sat_q;
    mask_d  = mask_q;

    unique case (state_q)
      ST_EMPTY: ;
      ST_MULT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FULL;
          res_d   = alu_res;
          zero_d  = alu_zero;
          ovf_d   = alu_ovf;
        end
      end
      ST_FULL: begin
        if (take) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // An accept only happens from EMPTY or from FULL on a take, so it
    // overrides whatever the case above chose.
    if (accept) begin
      a_d    = a_live;
      b_d    = b_live;
      op_d   = op_live;
      sat_d  = sat;
      mask_d = lane_mask;
      if (is_mul_live) begin
        state_d = ST_MULT;
        cnt_d   = CNT_W'(MUL_LAT - 1);
      end else begin
        state_d = ST_FULL;
        res_d   = alu_res;
        zero_d  = alu_zero;
        ovf_d   = alu_ovf;
      end
    end

    if (flush) begin
      state_d = ST_EMPTY;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= '0;
      ovf_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      sat_q   <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sat_q   <= sat_d;
      mask_q  <= mask_d;
    end
  end

  assign result    = res_q;
  assign lane_zero = zero_q;
  assign lane_ovf  = ovf_q;

endmodule

// File: tb/tb_vexec_pipe.sv
// tb_vexec_pipe: self-checking bench for vexec_pipe (table vectors, hand sequences, random vs model).
// Latency: n/a.
// Backpressure: exercises out_ready stalls, flush and reset aborts.
module tb_vexec_pipe;

  localparam int LANES   = 8;
  localparam int LANE_W  = 32;
  localparam int MUL_LAT = 3;
  localparam int FRAC    = 8;
  localparam int VW      = LANES * LANE_W;
  localparam longint LMAX = 64'sd2147483647;
  localparam longint LMIN = -64'sd2147483648;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        op = '0;
  logic              sat = 1'b0;
  logic              a_fwd = 1'b0, b_fwd = 1'b0, a_vsel = 1'b0, b_vsel = 1'b0;
  logic [LANE_W-1:0] a_s = '0, b_s = '0, fwd_s = '0;
  logic [VW-1:0]     a_v = '0, b_v = '0, fwd_v = '0;
  logic [LANES-1:0]  lane_mask = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [VW-1:0]     result;
  logic [LANES-1:0]  lane_zero;
  logic [LANES-1:0]  lane_ovf;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vexec_pipe #(.LANES(LANES), .LANE_W(LANE_W), .MUL_LAT(MUL_LAT), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .sat(sat),
    .a_fwd(a_fwd), .b_fwd(b_fwd), .a_vsel(a_vsel), .b_vsel(b_vsel),
    .a_s(a_s), .b_s(b_s), .fwd_s(fwd_s), .a_v(a_v), .b_v(b_v), .fwd_v(fwd_v),
    .lane_mask(lane_mask), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .lane_zero(lane_zero), .lane_ovf(lane_ovf), .busy(busy)
  );

  typedef struct {
    logic [2:0]        op;
    logic              sat, a_fwd, b_fwd, a_vsel, b_vsel;
    logic [LANE_W-1:0] a_s, b_s, fwd_s;
    logic [VW-1:0]     a_v, b_v, fwd_v;
    logic [LANES-1:0]  mask;
  } txn_t;

  typedef struct {
    logic [2:0]  op;
    logic        sat;
    logic [31:0] a, b, exp_r;
    logic        exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic txn_t bcast(input logic [2:0] o, input logic s, input logic [31:0] a, input logic [31:0] b);
    txn_t t;
    t.op = o; t.sat = s; t.a_fwd = 0; t.b_fwd = 0; t.a_vsel = 0; t.b_vsel = 0;
    t.a_s = a; t.b_s = b; t.fwd_s = '0; t.a_v = '0; t.b_v = '0; t.fwd_v = '0;
    t.mask = '1;
    return t;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 1023));
      3: return -32'($urandom_range(1, 1023));
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    t.op = 3'($urandom_range(0, 7));
    t.sat = 1'($urandom); t.a_fwd = 1'($urandom); t.b_fwd = 1'($urandom);
    t.a_vsel = 1'($urandom); t.b_vsel = 1'($urandom);
    t.a_s = rnd_val(); t.b_s = rnd_val(); t.fwd_s = rnd_val();
    for (int i = 0; i < LANES; i++) begin
      t.a_v[i*32 +: 32] = rnd_val();
      t.b_v[i*32 +: 32] = rnd_val();
      t.fwd_v[i*32 +: 32] = rnd_val();
    end
    t.mask = ($urandom_range(0, 1) == 0) ? '1 : 8'($urandom);
    return t;
  endfunction

  // Reference lane: exact 64-bit arithmetic, then range checks against 32-bit signed.
  task automatic ref_lane(input logic [2:0] o, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic m, output logic [31:0] r, output logic z, output logic ov);
    longint sa, sb, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v = 0; r = '0; ov = 1'b0;
    case (o)
      3'd0, 3'd1, 3'd6: begin
        if (o == 3'd0) v = sa + sb;
        else if (o == 3'd1) v = sa - sb;
        else v = (sa * sb) >>> FRAC;
        ov = (v > LMAX) || (v < LMIN);
        if (s && v > LMAX) r = 32'h7FFF_FFFF;
        else if (s && v < LMIN) r = 32'h8000_0000;
        else r = v[31:0];
      end
      3'd2: begin
        v = sa * sb;
        ov = (v > LMAX) || (v < LMIN);
        r = v[31:0];
      end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a >> b[4:0];
      default: r = '0;
    endcase
    if (!m) begin
      r = a;
      ov = 1'b0;
    end
    z = (r == '0);
  endtask

  function automatic logic [31:0] pick(input logic fwd, input logic vsel, input logic [31:0] s,
                                       input logic [31:0] fs, input logic [VW-1:0] v,
                                       input logic [VW-1:0] fv, input int i);
    logic [VW-1:0] src;
    src = fwd ? fv : v;
    return vsel ? src[i*32 +: 32] : (fwd ? fs : s);
  endfunction

  task automatic model(input txn_t t, output logic [VW-1:0] r, output logic [LANES-1:0] z, output logic [LANES-1:0] ov);
    for (int i = 0; i < LANES; i++) begin
      logic [31:0] a, b, lr;
      logic lz, lo;
      a = pick(t.a_fwd, t.a_vsel, t.a_s, t.fwd_s, t.a_v, t.fwd_v, i);
      b = pick(t.b_fwd, t.b_vsel, t.b_s, t.fwd_s, t.b_v, t.fwd_v, i);
      ref_lane(t.op, t.sat, a, b, t.mask[i], lr, lz, lo);
      r[i*32 +: 32] = lr;
      z[i] = lz;
      ov[i] = lo;
    end
  endtask

  task automatic drive(input txn_t t);
    op = t.op; sat = t.sat; a_fwd = t.a_fwd; b_fwd = t.b_fwd; a_vsel = t.a_vsel; b_vsel = t.b_vsel;
    a_s = t.a_s; b_s = t.b_s; fwd_s = t.fwd_s; a_v = t.a_v; b_v = t.b_v; fwd_v = t.fwd_v;
    lane_mask = t.mask;
  endtask

  // Offer one op, measure latency, compare against the model, optionally stall, then take.
  task automatic run_op(input txn_t t, input int stall, input string nm,
                        output logic [VW-1:0] got, output logic [LANES-1:0] govf);
    logic [VW-1:0] er;
    logic [LANES-1:0] ez, eo;
    int lat, w;
    logic is_mul, bad;
    model(t, er, ez, eo);
    is_mul = (t.op == 3'd2) || (t.op == 3'd6);
    @(negedge clk);
    drive(t); in_valid = 1'b1; out_ready = 1'b0;
    #1;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); #1; w++; end
    chk({nm, "_accept"}, VW'(in_ready), VW'(1));
    @(negedge clk);
    in_valid = 1'b0;
    drive(rnd_txn());  // changing inputs after accept must not matter
    #1;
    lat = 1; bad = 1'b0;
    while (!out_valid && lat < MUL_LAT + 5) begin
      if (in_ready || !busy) bad = 1'b1;
      @(negedge clk); #1; lat++;
    end
    chk({nm, "_mult_flags"}, VW'(bad), VW'(0));
    chk({nm, "_latency"}, VW'(lat), VW'(is_mul ? MUL_LAT : 1));
    chk({nm, "_result"}, result, er);
    chk({nm, "_zero"}, VW'(lane_zero), VW'(ez));
    chk({nm, "_ovf"}, VW'(lane_ovf), VW'(eo));
    got = result;
    govf = lane_ovf;
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      #1;
      chk({nm, "_hold"}, result, er);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk({nm, "_taken"}, VW'(out_valid), VW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt[14];
    txn_t t, t2, t3;
    logic [VW-1:0] got, e1, e2, e3;
    logic [LANES-1:0] gov, ez, eo;
    logic seen;
    int w;

    vt[0]  = '{3'd0, 1'b0, 32'd5,         32'd3,         32'd8,         1'b0};
    vt[1]  = '{3'd1, 1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b1};
    vt[2]  = '{3'd1, 1'b0, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1};
    vt[3]  = '{3'd0, 1'b1, 32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 1'b1};
    vt[4]  = '{3'd0, 1'b0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b1};
    vt[5]  = '{3'd6, 1'b0, 32'h0000_0180, 32'h0000_0200, 32'h0000_0300, 1'b0};
    vt[6]  = '{3'd2, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
    vt[7]  = '{3'd2, 1'b1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 1'b0};
    vt[8]  = '{3'd3, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0};
    vt[9]  = '{3'd4, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0};
    vt[10] = '{3'd5, 1'b0, 32'h8000_0000, 32'd35,        32'h1000_0000, 1'b0};
    vt[11] = '{3'd7, 1'b1, 32'd5,         32'd3,         32'd0,         1'b0};
    vt[12] = '{3'd6, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};
    vt[13] = '{3'd6, 1'b0, 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_FFFF, 1'b0};

    // Reset state.
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", VW'(in_ready), VW'(0));
    chk("rst_out_valid", VW'(out_valid), VW'(0));
    chk("rst_busy", VW'(busy), VW'(0));
    chk("rst_result", result, '0);
    chk("rst_flags", VW'({lane_zero, lane_ovf}), VW'(0));
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", VW'(in_ready), VW'(1));

    // Broadcast scalar A, vector B.
    t = bcast(3'd0, 1'b0, 32'd5, 32'd0);
    t.b_vsel = 1'b1;
    for (int i = 0; i < LANES; i++) t.b_v[i*32 +: 32] = 32'(i);
    run_op(t, 0, "add_bcast", got, gov);
    for (int i = 0; i < LANES; i++) chk("add_bcast_lane", VW'(got[i*32 +: 32]), VW'(5 + i));

    // Table vectors, all lanes broadcast.
    for (int k = 0; k < 14; k++) begin
      t = bcast(vt[k].op, vt[k].sat, vt[k].a, vt[k].b);
      run_op(t, k % 3, $sformatf("vec%0d", k), got, gov);
      chk($sformatf("vec%0d_lane0", k), VW'(got[31:0]), VW'(vt[k].exp_r));
      chk($sformatf("vec%0d_ovf0", k), VW'(gov[0]), VW'(vt[k].exp_ovf));
    end

    // Write mask: only lane 0 written.
    t = bcast(3'd3, 1'b0, 32'd0, 32'h0F0F);
    t.a_vsel = 1'b1;
    t.a_v = {LANES{32'h0000_FFFF}};
    t.mask = 8'b0000_0001;
    run_op(t, 0, "mask", got, gov);
    chk("mask_lane0", VW'(got[31:0]), VW'(32'h0F0F));
    chk("mask_others", VW'(got[VW-1:32]), VW'({(LANES-1){32'h0000_FFFF}}));

    // Output stall then same-edge take and accept, then full throughput.
    t = bcast(3'd4, 1'b0, 32'hF0, 32'h0F);
    t2 = bcast(3'd0, 1'b0, 32'd100, 32'd23);
    t3 = bcast(3'd0, 1'b0, 32'd7, 32'd7);
    model(t, e1, ez, eo);
    model(t2, e2, ez, eo);
    model(t3, e3, ez, eo);
    @(negedge clk);
    drive(t); in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    drive(t2);
    #1;
    chk("stall_valid", VW'(out_valid), VW'(1));
    for (int k = 0; k < 4; k++) begin
      chk("stall_result", result, e1);
      chk("stall_in_ready", VW'(in_ready), VW'(0));
      @(negedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("takeacc_in_ready", VW'(in_ready), VW'(1));
    @(negedge clk);
    drive(t3);
    #1;
    chk("takeacc_valid", VW'(out_valid), VW'(1));
    chk("takeacc_result", result, e2);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("thru_result", result, e3);
    @(negedge clk); #1;
    chk("thru_drained", VW'(out_valid), VW'(0));
    out_ready = 1'b0;

    // Back-to-back multiplies: second accepted on the edge the first is taken.
    t = bcast(3'd2, 1'b0, 32'd6, 32'd7);
    t2 = bcast(3'd6, 1'b0, 32'h0000_0400, 32'h0000_0300);
    model(t, e1, ez, eo);
    model(t2, e2, ez, eo);
    @(negedge clk);
    drive(t); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    drive(t2);
    #1;
    w = 0;
    while (!out_valid && w < 20) begin @(negedge clk); #1; w++; end
    chk("b2b_first", result, e1);
    chk("b2b_in_ready", VW'(in_ready), VW'(1));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("b2b_busy", VW'({busy, out_valid}), VW'(2'b10));
    repeat (MUL_LAT - 1) @(negedge clk);
    #1;
    chk("b2b_second_valid", VW'(out_valid), VW'(1));
    chk("b2b_second", result, e2);
    @(negedge clk);
    out_ready = 1'b0;

    // Flush while idle with an offer pending: offer must be dropped.
    t = bcast(3'd0, 1'b0, 32'd1, 32'd1);
    @(negedge clk);
    drive(t); in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_idle_in_ready", VW'(in_ready), VW'(0));
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_idle_no_out", VW'(out_valid), VW'(0));

    // Flush of a held result.
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("flush_full_valid", VW'(out_valid), VW'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_full_dropped", VW'(out_valid), VW'(0));

    // Flush during a multiply with a new offer present.
    t = bcast(3'd2, 1'b0, 32'd3, 32'd4);
    @(negedge clk);
    drive(t); in_valid = 1'b1;
    @(negedge clk);
    drive(bcast(3'd0, 1'b0, 32'd9, 32'd9));
    flush = 1'b1;
    #1;
    chk("flush_mult_busy", VW'(busy), VW'(1));
    chk("flush_mult_in_ready", VW'(in_ready), VW'(0));
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_mult_empty", VW'({busy, out_valid, in_ready}), VW'(3'b001));
    seen = 1'b0;
    repeat (MUL_LAT + 1) begin @(negedge clk); #1; if (out_valid) seen = 1'b1; end
    chk("flush_mult_no_result", VW'(seen), VW'(0));

    // Reset during a multiply, with nonzero result and overflow flags held.
    run_op(bcast(3'd1, 1'b1, 32'h8000_0000, 32'd1), 0, "pre_rst", got, gov);
    @(negedge clk);
    drive(bcast(3'd2, 1'b0, 32'd3, 32'd4)); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rst_mid_busy_before", VW'(busy), VW'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", VW'({out_valid, busy, in_ready}), VW'(0));
    chk("rst_mid_result", result, '0);
    chk("rst_mid_zero", VW'(lane_zero), VW'(0));
    chk("rst_mid_ovf", VW'(lane_ovf), VW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_ready_after", VW'(in_ready), VW'(1));
    seen = 1'b0;
    repeat (MUL_LAT + 1) begin @(negedge clk); #1; if (out_valid) seen = 1'b1; end
    chk("rst_mid_no_result", VW'(seen), VW'(0));

    // Random traffic against the model.
    for (int n = 0; n < 150; n++) begin
      run_op(rnd_txn(), $urandom_range(0, 2), $sformatf("rnd%0d", n), got, gov);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vexec_pipe.md
# vexec_pipe

Parametrised, registered successor to the processor's combinational execute stage. Applies one SIMD operation across `LANES` lanes of `LANE_W` bits, adds the following over the combinational stage:
- per-lane write masking;
- optional signed saturation;
- a fixed-point multiply for interpolation;
- a multi-cycle multiply path.

Sits between decode/operand-fetch and memory/writeback, with valid/ready handshakes on both sides so the pipeline can stall on multiplies.

## Interface
Parameters:
- `LANES`, 8, number of lanes
- `LANE_W`, 32, lane width in bits
- `MUL_LAT`, 3, cycles from accept to result for MUL/MULQ (≥2)
- `FRAC`, 8, fractional bits for MULQ

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operation offered
- `in_ready`  out  1  operation accepted when `in_valid && in_ready`
- `op`  in  3  0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 SRL, 6 MULQ, 7 reserved
- `sat`  in  1  saturate ADD/SUB/MULQ to signed range
- `a_fwd`, `b_fwd`  in  1 each  select forwarded operand instead of register operand
- `a_vsel`, `b_vsel`  in  1 each  1 = use vector operand, 0 = broadcast scalar to all lanes
- `a_s`, `b_s`, `fwd_s`  in  LANE_W each  scalar register and forwarded operands
- `a_v`, `b_v`, `fwd_v`  in  LANES*LANE_W each  vector register and forwarded operands (lane i at bits [i*LANE_W +: LANE_W])
- `lane_mask`  in  LANES  1 = lane written; 0 = lane result equals operand A lane
- `flush`  in  1  discard in-flight and held result
- `out_valid`  out  1  result held
- `out_ready`  in  1  consumer takes result when `out_valid && out_ready`
- `result`  out  LANES*LANE_W  lane results
- `lane_zero`  out  LANES  lane result == 0
- `lane_ovf`  out  LANES  signed overflow before saturation (0 for AND/OR/SRL/reserved, and for masked lanes)
- `busy`  out  1  multiply in flight

## Operation
Operand selection, per side, at accept:
- The fwd bit chooses forwarded vs register source.
- The vsel bit then chooses the vector, or the scalar replicated LANES times.

Per-lane arithmetic, with A and B signed `LANE_W`:
- ADD/SUB:
  - Wrap result by default.
  - Overflow is signed overflow.
  - With `sat`, clamp to max 2^(LANE_W-1)-1 or min -2^(LANE_W-1).
- MUL:
  - Low `LANE_W` bits of the signed 2·LANE_W product.
  - ovf = product does not fit `LANE_W` signed.
  - `sat` ignored.
- MULQ:
  - Product arithmetic-shifted right by `FRAC`, truncated toward −∞.
  - ovf = shifted value does not fit.
  - With `sat`, clamp.
- AND/OR: bitwise.
- SRL: logical shift of A by B[$clog2(LANE_W)-1:0].
- op 7: result 0, flags 0.

Masking:
- Masked lanes output the selected A lane unchanged.
- `lane_zero` is computed on the final (post-mask) lane value.

State machine:
- EMPTY:
  - `in_ready`=1.
  - Accepting a single-cycle op → FULL.
  - Accepting MUL/MULQ → MULT, counter = MUL_LAT-1.
- MULT:
  - `in_ready`=0, `busy`=1.
  - Counter decrements each cycle.
  - At 1 → FULL, with result registered from the operands captured at accept.
- FULL:
  - `out_valid`=1.
  - `in_ready` = `out_ready`.
  - On a take: a same-cycle accept follows the EMPTY rules, else → EMPTY.
  - Without a take: hold `result`/flags stable.
- `flush` (any state) → EMPTY next cycle.
  - Beats a simultaneous accept: `in_ready` is forced 0 while `flush`=1.
  - Any take in the same cycle still counts as a take.

## Timing
- Reset values:
  - State EMPTY, `out_valid`=0, `busy`=0, `result`=0, `lane_zero`=0, `lane_ovf`=0, counter 0.
  - `in_ready`=1 after reset (0 while `rst_n`=0).
- Single-cycle ops:
  - Accepted at edge N; `out_valid`=1 after edge N.
  - Full throughput of one op per cycle when `out_ready`=1.
- MUL/MULQ: accepted at edge N; `out_valid`=1 after edge N+MUL_LAT-1.
- Back-to-back multiplies: the next multiply can be accepted on the edge its predecessor is taken.
- Inputs are sampled only at accept. Input changes during MULT have no effect.
- `rst_n` asserted mid-multiply: state, outputs and counter return to reset values immediately. No result is produced.

## Structure
- Package `vexec_pkg`:
  - `op_t` enum (ADD…RSVD);
  - `state_t` (EMPTY, MULT, FULL);
  - helper function for signed saturation.
- Sub-module `vexec_lane`:
  - Combinational per-lane ALU, saturation and overflow detection.
  - Parameters `LANE_W` and `FRAC`.
  - Instantiated `LANES` times by generate.
- Top level holds operand muxes, operand capture registers, counter, FSM and output registers.

## Test plan
- Reset, then ADD with LANES=8, a_s=5 broadcast, b_v lane i = i: → after 1 cycle, `result` lane i = 5+i, `lane_zero`=0.
- SUB with `sat`=1, A=0x8000_0000, B=1: → lane = 0x8000_0000, `lane_ovf`=1. Same with `sat`=0: → 0x7FFF_FFFF, ovf=1.
- MULQ, FRAC=8, A=0x0000_0180 (1.5), B=0x0000_0200 (2.0): → 0x0000_0300. `in_ready`=0 for MUL_LAT-1 cycles. `out_valid` rises exactly MUL_LAT-1 cycles after accept.
- `out_ready`=0 for 4 cycles after an OR result: → `result` stable and `in_ready`=0. Then `out_ready`=1 with a new ADD offered: → take and accept on the same edge.
- `lane_mask`=8'b0000_0001, AND of a_v lanes 0xFFFF with b_s=0x0F0F: → lane 0 = 0x0F0F, lanes 1-7 = a_v lanes unchanged.
- Two mid-operation aborts:
  - `flush` during MULT with `in_valid`=1: → EMPTY next cycle, `out_valid` never rises, `in_ready`=0 in the flush cycle.
  - `rst_n` low during MULT: → all outputs at reset values asynchronously.
